// File: rtl/ctrl_pkg.sv
// Shared constants for the alu_ctrl_fsm sequencer: opcodes, state encoding
// and the default instruction width.
package ctrl_pkg;

    localparam int DEFAULT_IW = 9;

    localparam logic [2:0] OP_STP  = 3'b000;
    localparam logic [2:0] OP_SHF  = 3'b001;
    localparam logic [2:0] OP_BNEG = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b110;
    localparam logic [2:0] OP_LD   = 3'b111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode classifier for alu_ctrl_fsm: maps the 3-bit opcode
// to the class flags that steer the sequencer.
module alu_ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [2:0] op,
    output logic       is_halt,
    output logic       is_branch,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_imm,
    output logic       needs_wb
);

    // opcode to class-flag table
    always_comb begin
        is_halt   = 1'b0;
        is_branch = 1'b0;
        is_mem    = 1'b0;
        is_store  = 1'b0;
        is_imm    = 1'b0;
        needs_wb  = 1'b0;
        case (op)
            OP_STP:  is_halt = 1'b1;
            OP_SHF: begin
                is_imm   = 1'b1;
                needs_wb = 1'b1;
            end
            OP_BNEG: is_branch = 1'b1;
            OP_NOR:  needs_wb = 1'b1;
            OP_ADD:  needs_wb = 1'b1;
            OP_ADDI: begin
                is_imm   = 1'b1;
                needs_wb = 1'b1;
            end
            OP_ST: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_LD: begin
                is_mem   = 1'b1;
                needs_wb = 1'b1;
            end
            default: begin
                is_halt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) for the 8-bit core.
// Optional MEM-wait timeout enabled by defining ALU_CTRL_MEM_TIMEOUT_EN.
module alu_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int IW          = DEFAULT_IW,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IW-1:0]    instr,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             ir_ld,
    output logic             rf_we,
    output logic             rf_wsel_mem,
    output logic             mem_req,
    output logic             mem_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic [IW-1:0]    ir_r;
    logic [CNT_W-1:0] retired_r;
    logic [2:0]       op_s;
    logic             retire_s;
    logic             is_halt_s;
    logic             is_branch_s;
    logic             is_mem_s;
    logic             is_store_s;
    logic             is_imm_s;
    logic             needs_wb_s;
    logic [IW-4:0]    unused_ir_s;

    assign op_s        = ir_r[IW-1:IW-3];
    assign unused_ir_s = ir_r[IW-4:0];

    alu_ctrl_decode u_decode (
        .op        (op_s),
        .is_halt   (is_halt_s),
        .is_branch (is_branch_s),
        .is_mem    (is_mem_s),
        .is_store  (is_store_s),
        .is_imm    (is_imm_s),
        .needs_wb  (needs_wb_s)
    );

`ifdef ALU_CTRL_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              fault_r;
    logic              timeout_s;

    // wait counter restarts whenever the FSM is outside MEM, so it is zero on MEM entry
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= '0;
            fault_r    <= 1'b0;
        end else begin
            if (state_r != ST_MEM) begin
                wait_cnt_r <= '0;
            end else if (!mem_ack) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (timeout_s) begin
                fault_r <= 1'b1;
            end else begin
                fault_r <= fault_r;
            end
        end
    end

    assign fault = fault_r;
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = MEM_TIMEOUT;
    assign fault            = 1'b0;
`endif

    // next-state and strobe decode; pc_load/pc_inc in EXEC follow alu_zero directly
    always_comb begin
        state_nx_s  = state_r;
        alu_op      = 3'b000;
        alu_src_imm = 1'b0;
        ir_ld       = 1'b0;
        rf_we       = 1'b0;
        rf_wsel_mem = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        retire_s    = 1'b0;
`ifdef ALU_CTRL_MEM_TIMEOUT_EN
        timeout_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                ir_ld      = 1'b1;
                state_nx_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_halt_s) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op      = op_s;
                alu_src_imm = is_imm_s;
                if (is_branch_s) begin
                    if (alu_zero) begin
                        pc_inc = 1'b1;
                    end else begin
                        pc_load = 1'b1;
                    end
                    retire_s   = 1'b1;
                    state_nx_s = ST_FETCH;
                end else if (is_mem_s) begin
                    state_nx_s = ST_MEM;
                end else if (needs_wb_s) begin
                    state_nx_s = ST_WB;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                alu_op  = op_s;
                mem_req = 1'b1;
                mem_we  = is_store_s;
                if (mem_ack) begin
                    if (is_store_s) begin
                        pc_inc     = 1'b1;
                        retire_s   = 1'b1;
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s = ST_WB;
                    end
                end else begin
`ifdef ALU_CTRL_MEM_TIMEOUT_EN
                    // an ack on the limiting cycle takes the branch above instead
                    if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        timeout_s  = 1'b1;
                        state_nx_s = ST_HALT;
                    end else begin
                        state_nx_s = ST_MEM;
                    end
`else
                    state_nx_s = ST_MEM;
`endif
                end
            end
            ST_WB: begin
                alu_op      = op_s;
                alu_src_imm = is_imm_s;
                rf_we       = 1'b1;
                rf_wsel_mem = is_mem_s & ~is_store_s;
                pc_inc      = 1'b1;
                retire_s    = 1'b1;
                state_nx_s  = ST_FETCH;
            end
            ST_HALT: begin
                state_nx_s = ST_HALT;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // state, instruction register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ir_r      <= '0;
            retired_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (ir_ld) begin
                ir_r <= instr;
            end else begin
                ir_r <= ir_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    assign busy    = (state_r != ST_IDLE) && (state_r != ST_HALT);
    assign halted  = (state_r == ST_HALT);
    assign retired = retired_r;

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 8-bit core.
- Fetches a 9-bit instruction into an internal instruction register (IR) and decodes opcode IR[8:6].
- Drives the 3-bit ALU opcode and the operand-select, register-file, memory and program-counter strobes through FETCH/DECODE/EXEC/MEM/WB.
- Sits between instruction memory, register file, ALU and data memory.

Parameters:
- IW, 9, instruction width; opcode is IR[IW-1:IW-3].
- CNT_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum MEM-state wait cycles; used only with the optional feature.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- start  in  1  leave IDLE and begin execution.
- instr  in  IW  instruction word from instruction memory.
- alu_zero  in  1  ALU zero flag.
- mem_ack  in  1  data memory has completed the current request.
- alu_op  out  3  opcode presented to the ALU.
- alu_src_imm  out  1  ALU operand B comes from the immediate (addi, shf).
- ir_ld  out  1  IR load strobe.
- rf_we  out  1  register-file write enable.
- rf_wsel_mem  out  1  write-back data comes from memory (ld).
- mem_req  out  1  data-memory request.
- mem_we  out  1  data-memory write (st).
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= branch target.
- busy  out  1  not in IDLE or HALT.
- halted  out  1  stp executed, or fault.
- fault  out  1  memory timeout (optional feature).
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Opcodes: 000 stp, 001 shf, 010 bneg, 011 nor, 100 add, 101 addi, 110 st, 111 ld.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset, effective at the next edge, from any state including mid-MEM:
  - State goes to IDLE; IR and retired are cleared.
  - All strobes are 0, alu_op=000, halted=0, fault=0.
  - mem_req drops at that edge.
- IDLE: all strobes 0. start=1 -> FETCH; otherwise stay.
- FETCH: ir_ld=1; IR<=instr at the edge; -> DECODE.
- DECODE: stp -> HALT. All other opcodes -> EXEC.
- alu_op: equals IR[8:6] in EXEC, MEM and WB; 000 in every other state.
- alu_src_imm: 1 in EXEC/WB for addi and shf only.
- EXEC transitions:
  - bneg: alu_zero=0 -> pc_load=1 (combinational on alu_zero); alu_zero=1 -> pc_inc=1. Then -> FETCH, retired+1.
  - shf, nor, add, addi: -> WB.
  - ld, st: -> MEM.
- MEM: mem_req=1; mem_we=1 only for st. Stay until mem_ack=1. Then:
  - ld -> WB.
  - st: pc_inc=1, -> FETCH, retired+1.
- mem_ack outside MEM is ignored.
- WB: rf_we=1; rf_wsel_mem=1 for ld; pc_inc=1; -> FETCH; retired+1.
- HALT: halted=1, all strobes 0. Stays until reset; start is ignored.
- Latency: bneg 3 cycles; ALU ops 4 cycles; st 4+N cycles, ld 5+N cycles, N = extra mem wait cycles.
- pc_inc and pc_load are never both 1.
- retired wraps modulo 2^CNT_W.
- start while busy is ignored.

Optional Feature:
- Macro: ALU_CTRL_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on MEM entry.
  - If MEM_TIMEOUT consecutive MEM cycles pass without mem_ack -> HALT with fault=1, halted=1, mem_req dropped, no retire.
  - mem_ack arriving in the same cycle the limit is reached wins (normal completion).
- Undefined: MEM waits indefinitely; fault is tied 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_STP ... OP_LD);
  - state encoding constants;
  - IW default.
- Sub-module alu_ctrl_decode (combinational) takes IR[8:6] and produces class flags: is_halt, is_branch, is_mem, is_store, is_imm, needs_wb.

Test Plan:
- add: reset 2 cycles, start=1, instr=9'b100_000001 -> FETCH, DECODE, EXEC(alu_op=100), WB(rf_we=1, pc_inc=1); retired=1 after the 4th cycle.
- bneg:
  - instr=9'b010_000000, alu_zero=0 in EXEC -> pc_load=1, pc_inc=0, 3-cycle latency.
  - Repeat with alu_zero=1 -> pc_inc=1, pc_load=0.
- ld with mem_ack delayed 3 cycles -> mem_req=1, mem_we=0 held 4 cycles; then WB with rf_wsel_mem=1; retired+1. st variant -> mem_we=1, no WB.
- stp (9'b000_000000) -> HALT, halted=1. Pulse start=1 -> no change. reset=1 -> IDLE, halted=0.
- Reset asserted mid-MEM -> next edge: mem_req=0, state IDLE, retired=0.
- ALU_CTRL_MEM_TIMEOUT_EN with MEM_TIMEOUT=15, mem_ack never asserted -> fault=1 and halted=1 after 15 MEM cycles. Macro undefined -> still in MEM at cycle 100.
